// File: rtl/seg_display_pkg.sv
// Shared types and constants for the two-digit multiplexed 7-segment driver.
package seg_display_pkg;

    typedef enum logic [1:0] {
        S_DIG_LOW  = 2'd0,
        S_GAP_LOW  = 2'd1,
        S_DIG_HIGH = 2'd2,
        S_GAP_HIGH = 2'd3
    } state_t;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [1:0] AN_OFF    = 2'b11;

endpackage

// File: rtl/hex_to_7seg.sv
// Hex digit to active-low 7-segment pattern, segment order {g,f,e,d,c,b,a}.
module hex_to_7seg
    import seg_display_pkg::*;
(
    input  logic [3:0] hex,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (hex)
            4'h0: seg = 7'h40;
            4'h1: seg = 7'h79;
            4'h2: seg = 7'h24;
            4'h3: seg = 7'h30;
            4'h4: seg = 7'h19;
            4'h5: seg = 7'h12;
            4'h6: seg = 7'h02;
            4'h7: seg = 7'h78;
            4'h8: seg = 7'h00;
            4'h9: seg = 7'h10;
            4'hA: seg = 7'h08;
            4'hB: seg = 7'h03;
            4'hC: seg = 7'h46;
            4'hD: seg = 7'h21;
            4'hE: seg = 7'h06;
            4'hF: seg = 7'h0E;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seg_display2.sv
// Two-digit multiplexed common-anode driver with per-frame digit snapshot,
// blanking gaps between slots and a stretched overflow decimal point.
//
// state      | meaning
// S_DIG_LOW  | low digit lit (an=10)
// S_GAP_LOW  | all off after low slot
// S_DIG_HIGH | high digit lit (an=01), dp shows overflow stretch
// S_GAP_HIGH | all off after high slot; leaving it snapshots both digits
module seg_display2
    import seg_display_pkg::*;
#(
    parameter int REFRESH_DIV   = 50000,
    parameter int GAP_CYCLES    = 500,
    parameter int OVF_HOLD      = 100,
    parameter int BLANK_LEADING = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] value_low,
    input  logic [3:0] value_high,
    input  logic       overflow,
    output logic [6:0] seg,
    output logic       dp,
    output logic [1:0] an
);

    localparam int CNT_MAX = (REFRESH_DIV > GAP_CYCLES) ? REFRESH_DIV : GAP_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int OVF_W   = $clog2(OVF_HOLD + 1);

    localparam logic [CNT_W-1:0] DIG_LAST = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES - 1);
    localparam logic [OVF_W-1:0] OVF_LOAD = OVF_W'(OVF_HOLD);

    state_t             state_q, state_n;
    logic [CNT_W-1:0]   cnt_q, cnt_n;
    logic               slot_end;
    logic [3:0]         snap_low, snap_high;
    logic [OVF_W-1:0]   ovf_cnt;
    logic [3:0]         digit;
    logic [6:0]         digit_seg;
    logic [6:0]         seg_n;
    logic [1:0]         an_n;
    logic               dp_n;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_GAP_HIGH;
            cnt_q   <= '0;
        end else begin
            state_q <= state_n;
            cnt_q   <= cnt_n;
        end
    end

    always_comb begin
        state_n  = state_q;
        cnt_n    = cnt_q + CNT_W'(1);
        slot_end = (state_q == S_DIG_LOW || state_q == S_DIG_HIGH) ?
                   (cnt_q == DIG_LAST) : (cnt_q == GAP_LAST);
        if (slot_end) begin
            cnt_n = '0;
            case (state_q)
                S_DIG_LOW:  state_n = S_GAP_LOW;
                S_GAP_LOW:  state_n = S_DIG_HIGH;
                S_DIG_HIGH: state_n = S_GAP_HIGH;
                S_GAP_HIGH: state_n = S_DIG_LOW;
                default:    state_n = S_GAP_HIGH;
            endcase
        end
    end

    // Digits are frozen for the whole frame so a mid-frame update never tears.
    always_ff @(posedge clk) begin
        if (rst) begin
            snap_low  <= '0;
            snap_high <= '0;
        end else if (state_q == S_GAP_HIGH && slot_end) begin
            snap_low  <= value_low;
            snap_high <= value_high;
        end
    end

    // A fresh pulse wins over the end-of-high-slot decrement.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_cnt <= '0;
        end else if (overflow) begin
            ovf_cnt <= OVF_LOAD;
        end else if (state_q == S_DIG_HIGH && slot_end && ovf_cnt != '0) begin
            ovf_cnt <= ovf_cnt - OVF_W'(1);
        end
    end

    assign digit = (state_q == S_DIG_HIGH) ? snap_high : snap_low;

    hex_to_7seg u_hex (
        .hex (digit),
        .seg (digit_seg)
    );

    always_comb begin
        seg_n = SEG_BLANK;
        an_n  = AN_OFF;
        dp_n  = 1'b1;
        case (state_q)
            S_DIG_LOW: begin
                an_n  = 2'b10;
                seg_n = digit_seg;
            end
            S_DIG_HIGH: begin
                dp_n = (ovf_cnt == '0);
                if (BLANK_LEADING != 0 && snap_high == 4'h0) begin
                    // Keep the anode on only when the dp has something to show.
                    an_n = (ovf_cnt != '0) ? 2'b01 : AN_OFF;
                end else begin
                    an_n  = 2'b01;
                    seg_n = digit_seg;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            seg <= SEG_BLANK;
            dp  <= 1'b1;
            an  <= AN_OFF;
        end else begin
            seg <= seg_n;
            dp  <= dp_n;
            an  <= an_n;
        end
    end

endmodule

// File: tb/tb_seg_display2.sv
// Bench for seg_display2: frame-position reference model plus directed literal checks.
module tb_seg_display2;

    localparam int R = 4;
    localparam int G = 1;
    localparam int H = 2;
    localparam int F = 2 * (R + G);

    logic       clk;
    logic       rst;
    logic [3:0] value_low, value_high;
    logic       overflow;
    logic [6:0] seg_bl, seg_nb;
    logic       dp_bl, dp_nb;
    logic [1:0] an_bl, an_nb;

    int checks   = 0;
    int failures = 0;

    seg_display2 #(.REFRESH_DIV(R), .GAP_CYCLES(G), .OVF_HOLD(H), .BLANK_LEADING(1)) dut_bl (
        .clk(clk), .rst(rst), .value_low(value_low), .value_high(value_high),
        .overflow(overflow), .seg(seg_bl), .dp(dp_bl), .an(an_bl)
    );

    seg_display2 #(.REFRESH_DIV(R), .GAP_CYCLES(G), .OVF_HOLD(H), .BLANK_LEADING(0)) dut_nb (
        .clk(clk), .rst(rst), .value_low(value_low), .value_high(value_high),
        .overflow(overflow), .seg(seg_nb), .dp(dp_nb), .an(an_nb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [6:0] hex_tab [0:15] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                   7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Reference: e counts edges since the last reset edge; the frame position of
    // the cycle before edge e is (e-1) mod F, ordered gap-high, low, gap-low, high.
    int         e = 0;
    int         q;
    int         m_snap_l = 0, m_snap_h = 0, m_ovf = 0;
    bit         model_valid = 0;
    logic [6:0] x_seg [2];
    logic [1:0] x_an  [2];
    logic       x_dp  [2];

    always @(posedge clk) begin
        if (rst) begin
            e = 0; m_snap_l = 0; m_snap_h = 0; m_ovf = 0; model_valid = 1;
            for (int b = 0; b < 2; b++) begin
                x_seg[b] = 7'h7F; x_an[b] = 2'b11; x_dp[b] = 1'b1;
            end
        end else if (model_valid) begin
            q = e % F;
            for (int b = 0; b < 2; b++) begin
                x_seg[b] = 7'h7F; x_an[b] = 2'b11; x_dp[b] = 1'b1;
                if (q >= G && q < G + R) begin
                    x_an[b] = 2'b10; x_seg[b] = hex_tab[m_snap_l];
                end else if (q >= 2 * G + R) begin
                    x_dp[b] = (m_ovf == 0);
                    if (b == 1 && m_snap_h == 0) begin
                        x_an[b] = (m_ovf != 0) ? 2'b01 : 2'b11;
                    end else begin
                        x_an[b] = 2'b01; x_seg[b] = hex_tab[m_snap_h];
                    end
                end
            end
            e++;
            if (e % F == G) begin
                m_snap_l = int'(value_low);
                m_snap_h = int'(value_high);
            end
            if (overflow) m_ovf = H;
            else if (e % F == 0 && m_ovf > 0) m_ovf--;
        end
    end

    always @(negedge clk) begin
        if (model_valid) begin
            chk("model_seg_nb", {1'b0, seg_nb}, {1'b0, x_seg[0]});
            chk("model_an_nb",  {6'd0, an_nb},  {6'd0, x_an[0]});
            chk("model_dp_nb",  {7'd0, dp_nb},  {7'd0, x_dp[0]});
            chk("model_seg_bl", {1'b0, seg_bl}, {1'b0, x_seg[1]});
            chk("model_an_bl",  {6'd0, an_bl},  {6'd0, x_an[1]});
            chk("model_dp_bl",  {7'd0, dp_bl},  {7'd0, x_dp[1]});
        end
    end

    task automatic adv(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; value_low = 4'h0; value_high = 4'h0; overflow = 1'b0;
        adv(3);
        chk("rst_an",  {6'd0, an_bl},  8'h03);
        chk("rst_seg", {1'b0, seg_bl}, 8'h7F);
        chk("rst_dp",  {7'd0, dp_bl},  8'h01);

        value_low = 4'h3; value_high = 4'hA; rst = 1'b0;
        adv(1);  chk("first_gap_an", {6'd0, an_bl}, 8'h03);
        adv(1);  chk("low_an_e2",    {6'd0, an_bl}, 8'h02);
                 chk("low_seg_3",    {1'b0, seg_bl}, 8'h30);
        adv(3);  chk("low_an_e5",    {6'd0, an_bl}, 8'h02);
        adv(1);  chk("gap_low_an",   {6'd0, an_bl}, 8'h03);
        adv(1);  chk("high_an",      {6'd0, an_bl}, 8'h01);
                 chk("high_seg_A",   {1'b0, seg_bl}, 8'h08);
                 chk("high_dp",      {7'd0, dp_bl}, 8'h01);
        adv(5);  chk("period_an",    {6'd0, an_bl}, 8'h02);
                 chk("period_seg",   {1'b0, seg_bl}, 8'h30);

        value_high = 4'h0; value_low = 4'h7;
        adv(10); chk("lz_low_bl",    {1'b0, seg_bl}, 8'h78);
                 chk("lz_low_nb",    {1'b0, seg_nb}, 8'h78);
        adv(5);  chk("lz_an_bl",     {6'd0, an_bl}, 8'h03);
                 chk("lz_seg_bl",    {1'b0, seg_bl}, 8'h7F);
                 chk("lz_an_nb",     {6'd0, an_nb}, 8'h01);
                 chk("lz_seg_nb",    {1'b0, seg_nb}, 8'h40);

        value_low = 4'h5;
        adv(5);  chk("tear_seg_a",   {1'b0, seg_bl}, 8'h12);
        value_low = 4'h9;
        adv(3);  chk("tear_seg_b",   {1'b0, seg_bl}, 8'h12);
        adv(7);  chk("tear_seg_new", {1'b0, seg_bl}, 8'h10);

        overflow = 1'b1;
        adv(1);
        overflow = 1'b0;
        adv(4);  chk("ovf1_dp",      {7'd0, dp_bl}, 8'h00);
                 chk("ovf1_an_bl",   {6'd0, an_bl}, 8'h01);
                 chk("ovf1_seg_bl",  {1'b0, seg_bl}, 8'h7F);
        adv(10); chk("ovf2_dp",      {7'd0, dp_bl}, 8'h00);
        adv(10); chk("ovf3_dp",      {7'd0, dp_bl}, 8'h01);
                 chk("ovf3_an_bl",   {6'd0, an_bl}, 8'h03);

        adv(1);
        overflow = 1'b1;
        adv(1);
        overflow = 1'b0;
        adv(1);  chk("reload_dp",    {7'd0, dp_bl}, 8'h00);
        adv(7);  chk("reload2_dp",   {7'd0, dp_bl}, 8'h00);
        rst = 1'b1;
        adv(1);  chk("midrst_an",    {6'd0, an_bl}, 8'h03);
                 chk("midrst_dp",    {7'd0, dp_bl}, 8'h01);
        rst = 1'b0;

        for (int i = 0; i < 3000; i++) begin
            if ($urandom % 8 == 0) value_low = 4'($urandom);
            if ($urandom % 8 == 0) value_high = 4'($urandom % 3 == 0 ? 0 : $urandom);
            overflow = ($urandom % 25 == 0);
            rst      = ($urandom % 400 == 0);
            adv(1);
        end
        rst = 1'b0; overflow = 1'b0;
        adv(3);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule

// File: doc/seg_display2.md
Name: seg_display2

Overview:
- Two-digit multiplexed 7-segment driver directly downstream of the two-digit cascaded counter.
- Consumes value_low, value_high and the overflow pulse, and drives the board's common-anode display.
- Time-multiplexes the two hex digits with a blanking gap between slots to prevent ghosting.
- Snapshots both digits once per frame so the display never tears, and stretches the one-cycle overflow pulse into a visible decimal-point flash.

Parameters:
- REFRESH_DIV, 50000, clock cycles each digit is lit per slot; minimum 1.
- GAP_CYCLES, 500, clock cycles of all-off blanking after each digit slot; minimum 1.
- OVF_HOLD, 100, frames for which the decimal point stays lit after an overflow pulse; minimum 1.
- BLANK_LEADING, 1, when 1 the high digit is blanked if its snapshot equals 0.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, synchronous, active-high.
- value_low  in  4  low hex digit from the counter.
- value_high  in  4  high hex digit from the counter.
- overflow  in  1  single-cycle overflow pulse from the counter.
- seg  out  7  segments {g,f,e,d,c,b,a}, active-low.
- dp  out  1  decimal point, active-low.
- an  out  2  digit anodes, active-low; an[0] is the low digit, an[1] the high digit.

Behaviour:
- Clocking and reset:
  - One clock (clk); reset is synchronous and active-high (rst).
  - All outputs are registered.
  - Reset values: seg=7'h7F, dp=1, an=2'b11, FSM=S_GAP_HIGH, slot counter=0, snapshots=0, ovf_cnt=0.
- FSM cycle: S_DIG_LOW -> S_GAP_LOW -> S_DIG_HIGH -> S_GAP_HIGH -> S_DIG_LOW.
- Slot counter and timing:
  - Counts 0..N-1 per state: N=REFRESH_DIV in S_DIG_*, N=GAP_CYCLES in S_GAP_*.
  - At N-1 it clears and the FSM advances.
  - Frame length = 2*(REFRESH_DIV+GAP_CYCLES) cycles.
- Snapshot:
  - On the S_GAP_HIGH -> S_DIG_LOW transition edge, snap_low<=value_low and snap_high<=value_high.
  - Input changes at any other time are invisible until the next frame.
  - Latency from input to display is at most one frame plus 1 cycle.
- Output register:
  - Loaded from the current FSM state each cycle, so outputs lag the state by 1 cycle.
  - S_GAP_*: an=11, seg=7F, dp=1.
  - S_DIG_LOW: an=10, seg=hex(snap_low), dp=1.
  - S_DIG_HIGH, normal: an=01, seg=hex(snap_high), dp=(ovf_cnt==0).
  - S_DIG_HIGH, with BLANK_LEADING=1 and snap_high==0: seg=7F.
    - If ovf_cnt!=0: an=01 and dp=0 (only the dp is visible).
    - Otherwise: an=11.
- Hex table (active-low), values 0..F:
  - 40 79 24 30 19 12 02 78 00 10 08 03 46 21 06 0E.
- Overflow:
  - An overflow=1 in any cycle loads ovf_cnt<=OVF_HOLD.
  - ovf_cnt decrements by 1, saturating at 0, on each S_DIG_HIGH -> S_GAP_HIGH transition edge.
  - A simultaneous load and decrement resolves as a load.
  - Back-to-back pulses simply reload the counter.
- Width rules:
  - Slot counter width = $clog2(max(REFRESH_DIV,GAP_CYCLES)).
  - ovf_cnt width = $clog2(OVF_HOLD+1).
  - No wrap beyond N-1.
- Reset asserted mid-slot: outputs blank on the next edge, snapshots and ovf_cnt clear, and the sequence restarts from S_GAP_HIGH.

Decomposition:
- seg_display_pkg:
  - state_t enum (S_DIG_LOW, S_GAP_LOW, S_DIG_HIGH, S_GAP_HIGH).
  - SEG_BLANK=7'h7F.
  - AN_OFF=2'b11.
- hex_to_7seg: combinational 4-bit -> 7-bit active-low decoder; one instance, muxed by the digit being displayed.

Test Plan (REFRESH_DIV=4, GAP_CYCLES=1, OVF_HOLD=2):
- Reset: rst=1 for 3 cycles -> an=11, seg=7F, dp=1; after deassert, an=10 appears on the 2nd edge and lasts 4 cycles, followed by 1 cycle of an=11.
- Digits: value_low=3, value_high=A held -> seg=30 while an=10, seg=08 while an=01, repeating with a 10-cycle period.
- Leading blank: value_high=0, value_low=7 -> high slot an=11 with BLANK_LEADING=1; an=01, seg=40 with BLANK_LEADING=0; low slot always seg=78.
- Tear-free: change value_low 5->9 in the 2nd cycle of S_DIG_LOW -> seg stays 12 for the rest of the frame and shows 10 from the next S_DIG_LOW.
- Overflow: 1-cycle overflow pulse -> dp=0 during the next 2 high slots, dp=1 on the 3rd; a second pulse during the 2nd slot extends to 2 slots after that pulse.
- Reset mid-S_DIG_HIGH with ovf_cnt=1 -> next edge an=11, dp=1; the restarted frame shows snapshots 0.
